// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the sliced sequential adder.
// Holds the FSM state encoding and the default slice width.
package nibble_add_pkg;

  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/slice_adder.sv
// Combinational W-bit ripple-carry adder for one slice.
// Ports: a, b (W bits), cin -> s (W bits), cout.
module slice_adder
  import nibble_add_pkg::*;
#(
  parameter int W = SLICE_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Sequential adder: adds two WIDTH-bit operands SLICE bits per clock.
// In: Clk, Reset(n), LoadA/LoadB/Run(n buttons), SW. Out: Aval, Bval, Sum, CO, Busy, Done.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy,
  output logic             Done
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NS - 1);

  // Buttons bundled so one synchronizer/edge detector serves all three.
  // Bit 0 = LoadA, bit 1 = LoadB, bit 2 = Run.
  logic [2:0] btn;
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] press;

  assign btn   = {Run, LoadB, LoadA};
  assign press = s3_q & ~s2_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q <= '1;
      s2_q <= '1;
      s3_q <= '1;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  logic pa, pb, pr, run_up;
  assign pa     = press[0];
  assign pb     = press[1];
  assign pr     = press[2];
  assign run_up = s2_q[2];

  state_e           state_q;
  logic [WIDTH-1:0] aval_q, bval_q, sum_q;
  logic             co_q, busy_q, done_q, cy_q;
  logic [KW-1:0]    k_q;

  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_c;

  assign sl_a = aval_q[k_q*SLICE +: SLICE];
  assign sl_b = bval_q[k_q*SLICE +: SLICE];

  slice_adder #(.W(SLICE)) u_add (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (cy_q),
    .s    (sl_s),
    .cout (sl_c)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      aval_q  <= '0;
      bval_q  <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cy_q    <= 1'b0;
      k_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (pa) aval_q <= SW;
          if (pb) bval_q <= SW;
          if (state_q == IDLE) begin
            // A Run coinciding with a load is dropped.
            if (pr && !pa && !pb) begin
              state_q <= ADD;
              sum_q   <= '0;
              co_q    <= 1'b0;
              cy_q    <= 1'b0;
              k_q     <= '0;
              busy_q  <= 1'b1;
            end
          end else if (run_up) begin
            // Leave DONE only once Run is released.
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        ADD: begin
          sum_q[k_q*SLICE +: SLICE] <= sl_s;
          cy_q <= sl_c;
          k_q  <= k_q + 1'b1;
          if (k_q == KLAST) begin
            state_q <= DONE;
            co_q    <= sl_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Aval = aval_q;
  assign Bval = bval_q;
  assign Sum  = sum_q;
  assign CO   = co_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Randomised self-checking bench for nibble_add_seq.
// Reference model: plain integer addition of the loaded operands.
module tb_nibble_add_seq;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         LoadA = 1'b1;
  logic         LoadB = 1'b1;
  logic         Run = 1'b1;
  logic [W-1:0] SW = '0;
  logic [W-1:0] Aval, Bval, Sum;
  logic         CO, Busy, Done;

  int vecs = 0;
  int errs = 0;

  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;
  logic [W-1:0] msum = '0;
  logic         mco = 1'b0;

  nibble_add_seq #(.WIDTH(W), .SLICE(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .LoadA (LoadA),
    .LoadB (LoadB),
    .Run   (Run),
    .SW    (SW),
    .Aval  (Aval),
    .Bval  (Bval),
    .Sum   (Sum),
    .CO    (CO),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".aval"}, 32'(Aval), 0);
    chk({tag, ".bval"}, 32'(Bval), 0);
    chk({tag, ".sum"}, 32'(Sum), 0);
    chk({tag, ".co"}, 32'(CO), 0);
    chk({tag, ".busy"}, 32'(Busy), 0);
    chk({tag, ".done"}, 32'(Done), 0);
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    SW = a; LoadA = 1'b0; cyc(4); LoadA = 1'b1; cyc(3);
    ma = a;
    SW = b; LoadB = 1'b0; cyc(4); LoadB = 1'b1; cyc(3);
    mb = b;
    chk("load.a", 32'(Aval), 32'(ma));
    chk("load.b", 32'(Bval), 32'(mb));
  endtask

  // mode 0: plain add; 1: LoadA press during Busy; 2: reset in 2nd ADD cycle
  // hold: cycles to keep Run low after Done before release
  task automatic run_add(input int mode, input int hold);
    int n;
    logic [W:0] full;
    Run = 1'b0;
    n = 0;
    while (!Busy && n < 20) begin cyc(1); n++; end
    chk("busy.start", 32'(Busy), 1);
    if (mode == 1) begin
      SW = 16'hFFFF; LoadA = 1'b0;
    end
    if (mode == 2) begin
      cyc(1);
      #1 Reset = 1'b0;
      #1;
      chk_zero("rst_mid");
      ma = '0; mb = '0; msum = '0; mco = 1'b0;
      Run = 1'b1;
      cyc(2);
      Reset = 1'b1;
      cyc(3);
      chk_zero("rst_after");
      return;
    end
    n = 0;
    while (Busy && n < 20) begin cyc(1); n++; end
    full = {1'b0, ma} + {1'b0, mb};
    msum = full[W-1:0];
    mco = full[W];
    chk("busy.len", 32'(n), 4);
    chk("done", 32'(Done), 1);
    chk("sum", 32'(Sum), 32'(msum));
    chk("co", 32'(CO), 32'(mco));
    chk("aval.kept", 32'(Aval), 32'(ma));
    LoadA = 1'b1;
    n = 0;
    for (int i = 0; i < hold; i++) begin
      cyc(1);
      if (Busy || !Done) n++;
    end
    if (hold > 0) chk("hold.norestart", 32'(n), 0);
    Run = 1'b1;
    cyc(5);
    chk("idle.done", 32'(Done), 0);
    chk("idle.sum", 32'(Sum), 32'(msum));
    chk("idle.co", 32'(CO), 32'(mco));
  endtask

  initial begin
    #1;
    chk_zero("por");
    cyc(2);
    Reset = 1'b1;
    cyc(2);

    load(16'h0001, 16'h0002);
    run_add(0, 0);

    load(16'hFFFF, 16'h0001);
    run_add(0, 0);

    load(16'h1234, 16'h1111);
    run_add(1, 0);
    chk("intrude.a", 32'(Aval), 32'h1234);

    load(16'h5555, 16'h0AAA);
    run_add(2, 0);
    load(16'h00FF, 16'h0001);
    run_add(0, 0);

    load(16'h8000, 16'h8000);
    run_add(0, 20);
    load(16'h0F0F, 16'h00F1);
    run_add(0, 0);

    for (int t = 0; t < 12; t++) begin
      load(W'($urandom), W'($urandom));
      run_add(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 SHALL have parameter SLICE, default 4, meaning bits added per cycle; WIDTH SHALL be a multiple of SLICE.
REQ-003 SHALL have port Clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port LoadA  input  1  active-low push-button, load operand A from SW.
REQ-006 SHALL have port LoadB  input  1  active-low push-button, load operand B from SW.
REQ-007 SHALL have port Run  input  1  active-low push-button, start addition.
REQ-008 SHALL have port SW  input  WIDTH  switch operand value.
REQ-009 SHALL have port Aval  output  WIDTH  current operand A register, for display.
REQ-010 SHALL have port Bval  output  WIDTH  current operand B register, for display.
REQ-011 SHALL have port Sum  output  WIDTH  result register.
REQ-012 SHALL have port CO  output  1  carry-out of the full addition.
REQ-013 SHALL have port Busy  output  1  high while slices are being added.
REQ-014 SHALL have port Done  output  1  high while a completed result is held.

Function
REQ-015 SHALL pass LoadA, LoadB and Run each through a 2-FF synchronizer, then produce a one-cycle press pulse on the synchronized high-to-low transition.
REQ-016 SHALL implement FSM states IDLE, ADD, DONE.
REQ-017 In IDLE or DONE, a LoadA pulse SHALL load SW into Aval, and a LoadB pulse SHALL load SW into Bval, on the same edge.
REQ-018 Simultaneous LoadA and LoadB pulses SHALL load SW into both registers.
REQ-019 Load pulses in ADD SHALL be ignored.
REQ-020 A Run pulse in IDLE with no coincident load pulse SHALL move to ADD, clear Sum, CO and the slice index, and clear the carry register.
REQ-021 A Run pulse coincident with any load pulse SHALL be dropped.
REQ-022 In ADD, each clock SHALL add slice k of Aval, Bval and the carry register, write the result to Sum[k*SLICE +: SLICE], store the slice carry, and increment k.
REQ-023 After slice WIDTH/SLICE-1 is written, the FSM SHALL go to DONE and set CO to the final carry.
REQ-024 Busy SHALL be high for exactly WIDTH/SLICE cycles (4 cycles at the defaults).
REQ-025 Done SHALL be high the cycle after the last slice.
REQ-026 DONE SHALL return to IDLE only when the synchronized Run is high (button released); a held Run SHALL never restart.
REQ-027 Sum and CO SHALL hold their values through DONE and IDLE until the next accepted Run.
REQ-028 A Run pulse in ADD or DONE SHALL be ignored.

Reset
REQ-029 Reset low SHALL immediately, asynchronously, force state IDLE; Aval, Bval, Sum, CO, Busy, Done, carry and slice index to 0; and synchronizer flops to 1 (released).
REQ-030 Reset mid-ADD SHALL abort the addition with no partial result retained.
REQ-031 After Reset deasserts, the first accepted Run SHALL behave as from power-up.

Structure
REQ-032 Package nibble_add_pkg SHALL hold the FSM state enum and the default SLICE constant.
REQ-033 Sub-module slice_adder SHALL be the SLICE-bit combinational ripple adder, with inputs a, b, cin and outputs s, cout, instantiated once.
REQ-034 Synchronizer/edge-detect logic SHALL be written once and reused for all three buttons.

Verification
REQ-035 Assert Reset mid-activity -> Sum=0x0000, CO=0, Busy=0, Done=0, Aval=Bval=0 immediately, without a clock edge.
REQ-036 Load A=0x0001, B=0x0002, press Run -> Busy high 4 cycles, then Done=1, Sum=0x0003, CO=0.
REQ-037 A=0xFFFF, B=0x0001 -> Sum=0x0000, CO=1, with carry propagated through all 4 slices.
REQ-038 A=0x1234, B=0x1111, press LoadA with SW=0xFFFF during Busy -> Aval stays 0x1234, Sum=0x2345.
REQ-039 Reset pulsed during the 2nd ADD cycle -> IDLE, all zero; reload A=0x00FF, B=0x0001, Run -> Sum=0x0100, CO=0.
REQ-040 Hold Run low 20 cycles after DONE -> no restart, Done stays 1; release then press -> new addition runs.
